imem: RTL and testbench

- Read-only instruction memory for the single-cycle LEGv8-style processor.
- Holds a fixed 47-word test program. All other locations read as zero.
- Word-addressed: the datapath supplies PC[7:2] as `addr`.
- Read is combinational by default, so instruction fetch completes in the same cycle. An optional registered-output mode is selected by a parameter.

---
 rtl/imem.sv | 52 +++++
 tb/tb_imem.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/imem.sv
// Instruction ROM holding the fixed 47-word test program; every other word reads zero.
// Latency: 0 cycles (OUT_REG=0) or 1 cycle (OUT_REG=1). Backpressure: none, a word is available every cycle.
module imem #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] q
);

    function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = '0;
        case (32'(a))
            0:  w = 32'hf8000001;  1:  w = 32'hf8008002;  2:  w = 32'hf8000203;  3:  w = 32'h8b050083;
            4:  w = 32'hf8018003;  5:  w = 32'hcb050083;  6:  w = 32'hf8020003;  7:  w = 32'hcb0a03e4;
            8:  w = 32'hf8028004;  9:  w = 32'h8b040064;  10: w = 32'hf8030004;  11: w = 32'hcb030025;
            12: w = 32'hf8038005;  13: w = 32'h8a1f0145;  14: w = 32'hf8040005;  15: w = 32'h8a030145;
            16: w = 32'hf8048005;  17: w = 32'h8a140294;  18: w = 32'hf8050014;  19: w = 32'haa1f0166;
            20: w = 32'hf8058006;  21: w = 32'haa030166;  22: w = 32'hf8060006;  23: w = 32'hf840000c;
            24: w = 32'h8b1f0187;  25: w = 32'hf8068007;  26: w = 32'hf807000c;  27: w = 32'h8b0e01bf;
            28: w = 32'hf807801f;  29: w = 32'hb4000040;  30: w = 32'hf8080015;  31: w = 32'hf8088015;
            32: w = 32'h8b0103e2;  33: w = 32'hcb010042;  34: w = 32'h8b0103f8;  35: w = 32'hf8090018;
            36: w = 32'h8b080000;  37: w = 32'hb4ffff82;  38: w = 32'hf809001e;  39: w = 32'h8b1e03de;
            40: w = 32'hcb1503f5;  41: w = 32'h8b1403de;  42: w = 32'hf85f83d9;  43: w = 32'h8b1e03de;
            44: w = 32'h8b1003de;  45: w = 32'hf81f83d9;  46: w = 32'hb400001f;
            default: w = '0;
        endcase
        return w;
    endfunction

    logic [DATA_W-1:0] rom_dat;
    assign rom_dat = DATA_W'(rom_word(addr));

    generate
        if (OUT_REG != 0) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset) q <= '0;
                else       q <= rom_dat;
            end
        end else begin : g_comb
            // Pure lookup: clock and reset have no effect in this mode.
            logic unused_clk_reset;
            assign unused_clk_reset = clk ^ reset;
            assign q = rom_dat;
        end
    endgenerate

endmodule

// File: tb/tb_imem.sv
// Bench for imem: combinational and registered instances checked against a program-table model.
module tb_imem;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  addr_c = '0;
    logic [5:0]  addr_r = '0;
    logic [31:0] q_c;
    logic [31:0] q_r;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imem #(.ADDR_W(6), .DATA_W(32), .OUT_REG(0)) u_comb (
        .clk(clk), .reset(reset), .addr(addr_c), .q(q_c)
    );
    imem #(.ADDR_W(6), .DATA_W(32), .OUT_REG(1)) u_reg (
        .clk(clk), .reset(reset), .addr(addr_r), .q(q_r)
    );

    logic [31:0] prog [0:46];

    function automatic logic [31:0] model(input int a);
        if (a < 47) return prog[a];
        return 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  a;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [0:9];

    initial begin
        prog = '{32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083,
                 32'hf8018003, 32'hcb050083, 32'hf8020003, 32'hcb0a03e4,
                 32'hf8028004, 32'h8b040064, 32'hf8030004, 32'hcb030025,
                 32'hf8038005, 32'h8a1f0145, 32'hf8040005, 32'h8a030145,
                 32'hf8048005, 32'h8a140294, 32'hf8050014, 32'haa1f0166,
                 32'hf8058006, 32'haa030166, 32'hf8060006, 32'hf840000c,
                 32'h8b1f0187, 32'hf8068007, 32'hf807000c, 32'h8b0e01bf,
                 32'hf807801f, 32'hb4000040, 32'hf8080015, 32'hf8088015,
                 32'h8b0103e2, 32'hcb010042, 32'h8b0103f8, 32'hf8090018,
                 32'h8b080000, 32'hb4ffff82, 32'hf809001e, 32'h8b1e03de,
                 32'hcb1503f5, 32'h8b1403de, 32'hf85f83d9, 32'h8b1e03de,
                 32'h8b1003de, 32'hf81f83d9, 32'hb400001f};

        vecs[0] = '{6'd0,  32'hf8000001};
        vecs[1] = '{6'd3,  32'h8b050083};
        vecs[2] = '{6'd23, 32'hf840000c};
        vecs[3] = '{6'd29, 32'hb4000040};
        vecs[4] = '{6'd46, 32'hb400001f};
        vecs[5] = '{6'd47, 32'h00000000};
        vecs[6] = '{6'd63, 32'h00000000};
        vecs[7] = '{6'd37, 32'hb4ffff82};
        vecs[8] = '{6'd17, 32'h8a140294};
        vecs[9] = '{6'd50, 32'h00000000};

        // Registered instance reset state
        reset = 1'b1;
        addr_r = 6'd5;
        @(posedge clk); #1;
        check("reg_reset_state", q_r, 32'h0);

        // Combinational: table vectors
        for (int i = 0; i < 10; i++) begin
            addr_c = vecs[i].a;
            #1;
            check($sformatf("comb_vec[%0d]", i), q_c, vecs[i].exp);
        end

        // Combinational: full address sweep, 10 ns per step
        for (int a = 0; a < 64; a++) begin
            addr_c = 6'(a);
            #10;
            check($sformatf("comb_sweep[%0d]", a), q_c, model(a));
        end

        // Combinational: clk and reset activity must not disturb q
        addr_c = 6'd37;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            reset = (i % 2 == 0);
            #1;
            check("comb_hold_neg", q_c, 32'hb4ffff82);
            @(posedge clk); #1;
            check("comb_hold_pos", q_c, 32'hb4ffff82);
        end

        // Registered: reset held two edges, then release
        @(negedge clk);
        reset = 1'b1;
        addr_r = 6'd5;
        @(posedge clk); #1;
        check("reg_rst_edge1", q_r, 32'h0);
        @(posedge clk); #1;
        check("reg_rst_edge2", q_r, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reg_rst_release_pre", q_r, 32'h0);
        @(posedge clk); #1;
        check("reg_rst_release", q_r, 32'hcb050083);

        // Registered: address change between edges
        @(negedge clk);
        addr_r = 6'd42;
        @(posedge clk); #1;
        check("reg_addr42", q_r, 32'hf85f83d9);
        #2;
        addr_r = 6'd45;
        #1;
        check("reg_hold_after_change", q_r, 32'hf85f83d9);
        @(negedge clk); #1;
        check("reg_hold_negedge", q_r, 32'hf85f83d9);
        @(posedge clk); #1;
        check("reg_addr45", q_r, 32'hf81f83d9);

        // Registered: reset wins over a fetch of 45
        @(negedge clk);
        addr_r = 6'd46;
        @(posedge clk); #1;
        check("reg_addr46", q_r, 32'hb400001f);
        @(negedge clk);
        addr_r = 6'd45;
        reset = 1'b1;
        @(posedge clk); #1;
        check("reg_rst_priority", q_r, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized: both instances against the model, occasional reset
        for (int i = 0; i < 300; i++) begin
            logic [31:0] exp_r;
            @(negedge clk);
            addr_c = 6'($urandom_range(0, 63));
            addr_r = 6'($urandom_range(0, 63));
            reset = ($urandom_range(0, 15) == 0);
            exp_r = reset ? 32'h0 : model(int'(addr_r));
            #1;
            check("rand_comb", q_c, model(int'(addr_c)));
            @(posedge clk); #1;
            check("rand_reg", q_r, exp_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
